irda_nec_decoder: RTL and testbench
===================================

IRDA_NEC_DECODER -- requirements
Module: irda_nec_decoder

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50000000, input clock frequency used to derive a 1 us tick.
REQ-002 SHALL have port iCLK, input, 1, single clock; the only clock in the block.
REQ-003 SHALL have port iRST_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port iIRDA, input, 1, raw IR receiver output, asynchronous, idle high, burst = low.
REQ-005 SHALL have port oDATA_READY, output, 1, one-clock pulse per valid decoded frame.
REQ-006 SHALL have port oDATA, output, 32, last valid frame; bit i = i-th received bit (bits 7:0 address, 15:8 ~address, 23:16 command, 31:24 ~command).
REQ-007 SHALL have port oREPEAT, output, 1, one-clock pulse per valid NEC repeat code.

Function
REQ-008 SHALL pass iIRDA through a 2-flop synchronizer and a third flop for edge detection; all timing uses synchronized edges only.
REQ-009 SHALL generate a 1 us tick from a prescaler counting 0..CLK_FREQ_HZ/1000000-1; it restarts on every synchronized edge.
REQ-010 SHALL measure each phase with a 14-bit us counter, cleared on every edge, saturating at 16383.
REQ-011 SHALL implement states IDLE, LEAD_LOW, LEAD_HIGH, BIT_LOW, BIT_HIGH, RPT_TAIL.
REQ-012 IDLE: falling edge -> LEAD_LOW; other inputs ignored.
REQ-013 LEAD_LOW: rising edge with count 8000..10000 -> LEAD_HIGH; otherwise -> IDLE.
REQ-014 LEAD_HIGH: falling edge with count 4000..5000 -> BIT_LOW, bit index = 0; count 2000..2500 -> RPT_TAIL; otherwise -> IDLE.
REQ-015 BIT_LOW: rising edge with count 400..700 -> BIT_HIGH; otherwise -> IDLE.
REQ-016 BIT_HIGH: falling edge with count 400..700 shifts 0, count 1400..1900 shifts 1, into shift register position bit index; otherwise -> IDLE.
REQ-017 After bit 31 is shifted, the block SHALL latch oDATA, pulse oDATA_READY for exactly one clock, and return to IDLE (trailing 560 us burst ignored).
REQ-018 RPT_TAIL: rising edge with count 400..700 -> pulse oREPEAT one clock, -> IDLE; otherwise -> IDLE without pulse.
REQ-019 Timeout: in any non-IDLE state, counter reaching 16383 SHALL force IDLE.
REQ-020 Aborted or invalid frames SHALL NOT change oDATA or pulse any output.
REQ-021 Latency: oDATA_READY and the new oDATA value SHALL appear exactly 4 iCLK cycles after the iIRDA falling edge that ends bit 31.
REQ-022 oDATA SHALL hold its value between valid frames; oDATA_READY and oREPEAT SHALL never assert in the same cycle.
REQ-023 A falling edge arriving while a frame is in progress and failing its window SHALL abort that frame; a new leader is only recognised from IDLE.

Reset
REQ-024 iRST_n low SHALL asynchronously force state IDLE, oDATA = 0, oDATA_READY = 0, oREPEAT = 0, counters and shift register = 0, synchronizer flops = 1.
REQ-025 Reset asserted mid-frame SHALL discard the frame; decoding restarts with the next leader after release.

Configuration
REQ-026 Macro IRDA_CHECKSUM_EN: when defined, a frame is valid only if oDATA[15:8] == ~oDATA[7:0] and oDATA[31:24] == ~oDATA[23:16]; failing frames behave per REQ-020.
REQ-027 Without IRDA_CHECKSUM_EN, every 32-bit frame meeting timing SHALL be accepted unchanged.

Verification
REQ-028 Frame address 0x00, command 0x45 at nominal timing -> oDATA = 0xBA45FF00, one-clock oDATA_READY, 4 clocks after last falling edge.
REQ-029 Leader 9 ms low, 2.25 ms high, 560 us burst -> one oREPEAT pulse, oDATA unchanged, no oDATA_READY.
REQ-030 Valid frame with bit 12 high phase = 1000 us -> abort, no pulse, oDATA keeps previous 0xBA45FF00; next valid frame decodes normally.
REQ-031 With IRDA_CHECKSUM_EN, frame 0x0045FF00 (bad ~command) -> rejected; without the macro -> oDATA = 0x0045FF00 with pulse.
REQ-032 iRST_n pulsed low during bit 20 -> all outputs 0 immediately; following valid frame 0xF708FB04 decodes correctly.
REQ-033 Line held low 20 ms then released -> timeout to IDLE, no pulses; subsequent frame decodes correctly.

Source files
------------

// File: rtl/irda_nec_decoder.sv
// ---------------------------------------------------------------------------
// irda_nec_decoder
//   Decodes NEC-format IR remote frames from a raw IR receiver output.
//   Phases between synchronized edges are measured in microseconds and
//   checked against NEC timing windows; a complete 32-bit frame is latched
//   to oDATA with a one-clock oDATA_READY pulse, and a repeat code produces
//   a one-clock oREPEAT pulse. Aborted or out-of-window frames are dropped
//   silently.
//
//   Parameters:
//     CLK_FREQ_HZ  iCLK frequency, used to derive the 1 us tick
//   Ports:
//     iCLK         clock
//     iRST_n       asynchronous active-low reset
//     iIRDA        raw IR line (asynchronous, idle high, burst = low)
//     oDATA_READY  one-clock pulse per accepted frame
//     oDATA[31:0]  last accepted frame, bit i = i-th received bit
//     oREPEAT      one-clock pulse per valid repeat code
//
//   Optional build macro:
//     IRDA_CHECKSUM_EN  when defined, a frame is accepted only if its
//                       address and command bytes match their inverses.
// ---------------------------------------------------------------------------
module irda_nec_decoder #(
  parameter int CLK_FREQ_HZ = 50000000
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iIRDA,
  output logic        oDATA_READY,
  output logic [31:0] oDATA,
  output logic        oREPEAT
);

  localparam int DIV = (CLK_FREQ_HZ / 1000000 < 1) ? 1 : CLK_FREQ_HZ / 1000000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [13:0]   CNT_MAX = 14'h3FFF;

  typedef enum logic [2:0] {
    IDLE, LEAD_LOW, LEAD_HIGH, BIT_LOW, BIT_HIGH, RPT_TAIL
  } state_e;

  // Synchronizer + edge-detect flops; reset to the idle-high line level.
  logic s1_q, s2_q, s3_q;
  logic fall_w, rise_w, edge_w;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= iIRDA;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign fall_w = s3_q & ~s2_q;
  assign rise_w = ~s3_q & s2_q;
  assign edge_w = fall_w | rise_w;

  // 1 us tick; the prescaler restarts on each edge so every phase is
  // measured from a clean tick boundary.
  logic [PW-1:0] pre_q;
  logic [13:0]   cnt_q;
  logic          tick_w;

  assign tick_w = (pre_q == PRE_MAX) && !edge_w;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else if (edge_w) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
      if (tick_w && cnt_q != CNT_MAX) cnt_q <= cnt_q + 14'd1;
    end
  end

  function automatic logic in_win(input logic [13:0] c,
                                  input logic [13:0] lo,
                                  input logic [13:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // Frame FSM
  state_e      state_q, state_d;
  logic [4:0]  bit_idx_q, bit_idx_d;
  logic [31:0] shift_q, shift_d;
  logic        done_q, done_d;
  logic        rpt_q, rpt_d;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      shift_q   <= '0;
      done_q    <= 1'b0;
      rpt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
      rpt_q     <= rpt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    rpt_d     = 1'b0;
    if (state_q != IDLE && cnt_q == CNT_MAX) begin
      state_d = IDLE;
    end else if (edge_w) begin
      // Any edge that does not match the current phase window aborts the
      // frame; aborting lands in IDLE, so a new leader needs a fresh edge.
      state_d = IDLE;
      case (state_q)
        IDLE:
          if (fall_w) state_d = LEAD_LOW;
        LEAD_LOW:
          if (rise_w && in_win(cnt_q, 14'd8000, 14'd10000)) state_d = LEAD_HIGH;
        LEAD_HIGH:
          if (fall_w) begin
            if (in_win(cnt_q, 14'd4000, 14'd5000)) begin
              state_d   = BIT_LOW;
              bit_idx_d = '0;
            end else if (in_win(cnt_q, 14'd2000, 14'd2500)) begin
              state_d = RPT_TAIL;
            end
          end
        BIT_LOW:
          if (rise_w && in_win(cnt_q, 14'd400, 14'd700)) state_d = BIT_HIGH;
        BIT_HIGH:
          if (fall_w && (in_win(cnt_q, 14'd400, 14'd700) ||
                         in_win(cnt_q, 14'd1400, 14'd1900))) begin
            shift_d[bit_idx_q] = (cnt_q >= 14'd1400);
            if (bit_idx_q == 5'd31) begin
              done_d = 1'b1;   // trailing burst is left to IDLE to ignore
            end else begin
              bit_idx_d = bit_idx_q + 5'd1;
              state_d   = BIT_LOW;
            end
          end
        RPT_TAIL:
          if (rise_w && in_win(cnt_q, 14'd400, 14'd700)) rpt_d = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output stage: one register after the final shift so the data and the
  // ready pulse appear together.
  logic chk_ok_w;
`ifdef IRDA_CHECKSUM_EN
  assign chk_ok_w = (shift_q[15:8]  == ~shift_q[7:0]) &&
                    (shift_q[31:24] == ~shift_q[23:16]);
`else
  assign chk_ok_w = 1'b1;
`endif

  logic [31:0] data_q;
  logic        ready_q;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (done_q && chk_ok_w) begin
        data_q  <= shift_q;
        ready_q <= 1'b1;
      end
    end
  end

  assign oDATA       = data_q;
  assign oDATA_READY = ready_q;
  assign oREPEAT     = rpt_q;

endmodule

// File: tb/tb_irda_nec_decoder.sv
// Directed bench for irda_nec_decoder at 1 MHz (one clock per microsecond).
module tb_irda_nec_decoder;

  localparam int LEAD_L = 8030;
  localparam int LEAD_H = 4030;
  localparam int RPT_H  = 2030;
  localparam int BIT_L  = 430;
  localparam int ZERO_H = 430;
  localparam int ONE_H  = 1430;
`ifdef IRDA_CHECKSUM_EN
  localparam logic CK = 1'b1;
`else
  localparam logic CK = 1'b0;
`endif

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic        iIRDA = 1'b1;
  logic        oDATA_READY;
  logic [31:0] oDATA;
  logic        oREPEAT;

  int n_vec = 0, n_err = 0;
  int n_rdy = 0, n_rpt = 0, n_both = 0;
  logic [31:0] last_ok;

  irda_nec_decoder #(.CLK_FREQ_HZ(1000000)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iIRDA(iIRDA),
    .oDATA_READY(oDATA_READY), .oDATA(oDATA), .oREPEAT(oREPEAT)
  );

  always #5 iCLK = ~iCLK;

  always @(negedge iCLK) begin
    if (oDATA_READY) n_rdy++;
    if (oREPEAT) n_rpt++;
    if (oDATA_READY && oREPEAT) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    iIRDA = lvl;
    repeat (n) @(negedge iCLK);
  endtask

  task automatic lead();
    hold(1'b0, LEAD_L);
    hold(1'b1, LEAD_H);
  endtask

  task automatic send_bit(input logic b, input int hi);
    hold(1'b0, BIT_L);
    hold(1'b1, hi);
  endtask

  // Drives the falling edge that ends bit 31 and checks the 4-clock latency.
  task automatic finish_frame(input logic ok, input logic [31:0] exp);
    iIRDA = 1'b0;
    repeat (3) @(negedge iCLK);
    chk("rdy_early", {31'd0, oDATA_READY}, 32'd0);
    @(negedge iCLK);
    chk("rdy_pulse", {31'd0, oDATA_READY}, {31'd0, ok});
    chk("data", oDATA, exp);
    @(negedge iCLK);
    chk("rdy_one_clk", {31'd0, oDATA_READY}, 32'd0);
    repeat (BIT_L - 5) @(negedge iCLK);
    hold(1'b1, 200);
  endtask

  task automatic send_frame(input logic [31:0] d, input logic ok, input logic [31:0] exp);
    lead();
    for (int i = 0; i < 32; i++) send_bit(d[i], d[i] ? ONE_H : ZERO_H);
    finish_frame(ok, exp);
  endtask

  initial begin
    int r0;
    int p0;
    logic [31:0] d;
    // reset state
    repeat (3) @(negedge iCLK);
    chk("rst_data", oDATA, 32'd0);
    chk("rst_rdy", {31'd0, oDATA_READY}, 32'd0);
    chk("rst_rpt", {31'd0, oREPEAT}, 32'd0);
    iRST_n = 1'b1;
    hold(1'b1, 50);

    // nominal frame: address 0x00, command 0x45
    send_frame(32'hBA45FF00, 1'b1, 32'hBA45FF00);
    last_ok = 32'hBA45FF00;

    // repeat code
    p0 = n_rpt; r0 = n_rdy;
    hold(1'b0, LEAD_L);
    hold(1'b1, RPT_H);
    hold(1'b0, BIT_L);
    hold(1'b1, 300);
    chk("rpt_count", n_rpt - p0, 1);
    chk("rpt_no_rdy", n_rdy - r0, 0);
    chk("rpt_data", oDATA, last_ok);

    // bit 12 high phase 1000 us aborts the frame
    r0 = n_rdy; p0 = n_rpt;
    d = 32'hBA45FF00;
    lead();
    for (int i = 0; i < 13; i++) send_bit(d[i], (i == 12) ? 1000 : (d[i] ? ONE_H : ZERO_H));
    hold(1'b0, BIT_L);
    hold(1'b1, 300);
    chk("abort_no_rdy", n_rdy - r0, 0);
    chk("abort_no_rpt", n_rpt - p0, 0);
    chk("abort_data", oDATA, last_ok);

    // bad ~command byte: accepted only when checksum checking is off
    send_frame(32'h0045FF00, !CK, CK ? last_ok : 32'h0045FF00);
    if (!CK) last_ok = 32'h0045FF00;

    // reset asserted during bit 20
    d = 32'hF708FB04;
    lead();
    for (int i = 0; i < 20; i++) send_bit(d[i], d[i] ? ONE_H : ZERO_H);
    hold(1'b0, BIT_L);
    hold(1'b1, 100);
    #2 iRST_n = 1'b0;
    #1;
    chk("midrst_data", oDATA, 32'd0);
    chk("midrst_rdy", {31'd0, oDATA_READY}, 32'd0);
    chk("midrst_rpt", {31'd0, oREPEAT}, 32'd0);
    @(negedge iCLK);
    iRST_n = 1'b1;
    hold(1'b1, 300);

    // line stuck low 20 ms, then released
    r0 = n_rdy; p0 = n_rpt;
    hold(1'b0, 20000);
    hold(1'b1, 300);
    chk("tmo_no_rdy", n_rdy - r0, 0);
    chk("tmo_no_rpt", n_rpt - p0, 0);
    chk("tmo_data", oDATA, 32'd0);

    // clean frame after reset and timeout
    send_frame(32'hF708FB04, 1'b1, 32'hF708FB04);

    chk("total_rdy", n_rdy, CK ? 2 : 3);
    chk("total_rpt", n_rpt, 1);
    chk("never_both", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
